// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches one word per instruction over a
// req/ack memory handshake and holds it until the datapath retires it.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned TGT_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic [1:0]  branch,
  input  logic        br_taken,
  input  logic [31:0] jr_addr,
  output logic        fault
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SEXT_W = XLEN - IMM_W - 2;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_d, instr_d, npc, br_off, jal_tgt;
  logic        valid_d, req_d, fault_d;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Next-PC candidates; addition wraps modulo 2^32.
  assign br_off  = {{SEXT_W{instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  assign jal_tgt = {pc_plus4[XLEN-1:TGT_W+2], instr[TGT_W-1:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (branch)
      2'd1:    npc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
      2'd2:    npc = jal_tgt;
      2'd3:    npc = jr_addr;
      default: npc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      imem_req    <= req_d;
      fault       <= fault_d;
    end
  end

  // An ack only counts while our request is actually visible, so a stale ack after reset is dropped.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instr;
    valid_d = instr_valid;
    req_d   = imem_req;
    fault_d = fault;
    case (state)
      S_FETCH: begin
        req_d = 1'b1;
        if (imem_req && imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        req_d = 1'b0;
        if (retire) begin
          valid_d = 1'b0;
          if (npc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = npc;
            req_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FAULT: begin
        req_d = 1'b0;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed + randomized bench for ifu_fetch_ctrl against a plain-arithmetic PC model.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, instr_valid, retire, br_taken, fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, jr_addr;
  logic [1:0]  branch;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc, m_instr;

  ifu_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .retire(retire),
    .branch(branch), .br_taken(br_taken), .jr_addr(jr_addr), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] ins,
                                          input logic [1:0] br, input logic tk,
                                          input logic [31:0] jr);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    case (br)
      2'd0:    return seq;
      2'd1:    return tk ? seq + 32'(off) : seq;
      2'd2:    return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
      default: return jr;
    endcase
  endfunction

  task automatic fetch(input logic [31:0] rdata, input int lat);
    int t;
    t = 0;
    while (imem_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_rise", 32'(imem_req), 32'd1);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_plus4_fetch", pc_plus4, m_pc + 32'd4);
    repeat (lat) begin
      @(negedge clk);
      chk("req_hold", 32'(imem_req), 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_instr    = rdata;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr", instr, rdata);
    chk("pc_exec", pc, m_pc);
    chk("req_drop", 32'(imem_req), 32'd0);
  endtask

  task automatic execute(input logic [1:0] br, input logic tk, input logic [31:0] jr,
                         input int stall);
    logic [31:0] exp;
    branch   = br;
    br_taken = tk;
    jr_addr  = jr;
    retire   = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, m_instr);
      chk("stall_pc", pc, m_pc);
      chk("stall_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    exp    = ref_npc(m_pc, m_instr, br, tk, jr);
    retire = 1'b1;
    @(negedge clk);
    retire   = 1'b0;
    branch   = 2'($urandom);
    br_taken = 1'($urandom);
    jr_addr  = $urandom;
    chk("retire_valid", 32'(instr_valid), 32'd0);
    if (exp[1:0] != 2'b00) begin
      chk("fault_set", 32'(fault), 32'd1);
      chk("fault_pc", pc, m_pc);
      chk("fault_req", 32'(imem_req), 32'd0);
    end else begin
      m_pc = exp;
      chk("npc", pc, m_pc);
      chk("no_fault", 32'(fault), 32'd0);
      chk("refetch_req", 32'(imem_req), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    retire     = 1'b0;
    branch     = 2'd0;
    br_taken   = 1'b0;
    jr_addr    = '0;
    repeat (2) @(negedge clk);
    m_pc = RST_PC;
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    do_reset();

    // Basic fetch with wait states, sequential retire
    fetch(32'h3402_0005, 2);
    execute(2'd0, 1'b0, 32'h0, 0);

    // Conditional branch backward (taken) and fall-through
    fetch(32'h0000_0000, 0);
    execute(2'd3, 1'b0, 32'h0000_3010, 0);
    fetch(32'h1000_FFFE, 1);
    execute(2'd1, 1'b1, 32'h0000_0001, 0);
    chk("beq_taken_pc", pc, 32'h0000_300C);
    fetch(32'h0000_0000, 0);
    execute(2'd3, 1'b0, 32'h0000_3010, 0);
    fetch(32'h1000_FFFE, 0);
    execute(2'd1, 1'b0, 32'h0000_0002, 0);
    chk("beq_fall_pc", pc, 32'h0000_3014);

    // jal with a stall
    fetch(32'h0000_0000, 0);
    execute(2'd3, 1'b0, 32'h0000_3020, 0);
    fetch(32'h0800_0C10, 0);
    execute(2'd2, 1'b1, 32'h0000_0003, 2);
    chk("jal_pc", pc, 32'h0000_3040);

    // PC wrap at top of address space
    fetch(32'h0000_0000, 0);
    execute(2'd3, 1'b0, 32'hFFFF_FFFC, 0);
    fetch(32'h0000_0000, 0);
    execute(2'd0, 1'b1, 32'h0000_0007, 0);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Randomized traffic (aligned jr targets only)
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      fetch($urandom, int'($urandom_range(0, 3)));
      execute(2'($urandom), 1'($urandom), r, int'($urandom_range(0, 3)));
    end

    // Long stall
    fetch($urandom, 0);
    execute(2'd0, 1'b0, 32'h0, 10);

    // Reset mid-fetch; acks during and right after reset are ignored
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_req", 32'(imem_req), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = RST_PC;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_instr", instr, 32'd0);
    chk("post_rst_req", 32'(imem_req), 32'd1);

    // jr aligned, then misaligned -> fault
    fetch(32'h0000_0000, 0);
    execute(2'd3, 1'b0, 32'h0000_3008, 0);
    chk("jr_pc", pc, 32'h0000_3008);
    fetch(32'h0000_0000, 1);
    execute(2'd3, 1'b0, 32'h0000_3006, 0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1;
      retire   = 1'b1;
      branch   = 2'd0;
      @(negedge clk);
      chk("frz_req", 32'(imem_req), 32'd0);
      chk("frz_pc", pc, 32'h0000_3008);
      chk("frz_fault", 32'(fault), 32'd1);
      chk("frz_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b0;
    retire   = 1'b0;
    do_reset();
    @(negedge clk);
    chk("fault_exit_req", 32'(imem_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
